// File: rtl/multiword_addsub_seq_pkg.sv
// Shared definitions for the sequential multi-word adder/subtractor: FSM encoding and index sizing.
package multiword_addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Smallest width able to index v distinct values (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multiword_addsub_seq_rca_nbit.sv
// n-bit ripple-carry adder used as the shared chunk adder.
// Purely combinational, no latency, no flow control.
module rca_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic         i_c,
  output logic [n-1:0] o_s,
  output logic         o_c
);

  logic [n:0] w_c;

  assign w_c[0] = i_c;

  genvar g;
  generate
    for (g = 0; g < n; g++) begin : g_fa
      assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end
  endgenerate

  assign o_c = w_c[n];

endmodule

// File: rtl/multiword_addsub_seq.sv
// Multi-precision add/sub reusing one n-bit adder over WORDS cycles; result after WORDS+1 cycles.
// No backpressure: start is accepted only in IDLE and is dropped otherwise.
module multiword_addsub_seq
  import multiword_addsub_seq_pkg::*;
#(
  parameter int n     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 add_n,
  input  logic [n*WORDS-1:0]   x,
  input  logic [n*WORDS-1:0]   y,
  output logic                 busy,
  output logic                 done,
  output logic [n*WORDS-1:0]   s,
  output logic                 c_out,
  output logic                 over_flow
);

  localparam int N    = n * WORDS;
  localparam int IDXW = clog2(WORDS);

  state_t            r_state;
  state_t            w_next_state;
  logic [N-1:0]      r_x;
  logic [N-1:0]      r_y;
  logic              r_add_n;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [N-1:0]      r_s;
  logic              r_c_out;
  logic              r_ovf;

  logic [n-1:0]      w_a;
  logic [n-1:0]      w_b;
  logic [n-1:0]      w_sum;
  logic              w_co;
  logic              w_last;
  logic              w_ye;
  logic              w_sm;

  // Subtraction is x + ~y + 1: the +1 enters as the initial carry.
  assign w_a    = r_x[r_idx*n +: n];
  assign w_b    = r_y[r_idx*n +: n] ^ {n{r_add_n}};
  assign w_last = (r_idx == IDXW'(WORDS - 1));
  assign w_ye   = r_y[N-1] ^ r_add_n;
  assign w_sm   = w_sum[n-1];

  rca_nbit #(.n(n)) u_rca (
    .i_a (w_a),
    .i_b (w_b),
    .i_c (r_carry),
    .o_s (w_sum),
    .o_c (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_add_n <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_add_n <= add_n;
            r_carry <= add_n;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_s[r_idx*n +: n] <= w_sum;
          r_carry           <= w_co;
          if (w_last) begin
            r_c_out <= w_co;
            r_ovf   <= (r_x[N-1] & w_ye & ~w_sm) | (~r_x[N-1] & ~w_ye & w_sm);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign s         = r_s;
  assign c_out     = r_c_out;
  assign over_flow = r_ovf;

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Scoreboard bench for multiword_addsub_seq with n=4, WORDS=4 (N=16).
module tb_multiword_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        add_n;
  logic [15:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        c_out;
  logic        over_flow;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        ov;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multiword_addsub_seq #(.n(4), .WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .add_n     (add_n),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .s         (s),
    .c_out     (c_out),
    .over_flow (over_flow)
  );

  // Reference: full-width arithmetic with the sign rule stated on operand/result signs.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    exp_t        e;
    logic [16:0] t;
    if (sub) t = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else     t = {1'b0, a} + {1'b0, b};
    e.s = t[15:0];
    e.c = t[16];
    if (sub) e.ov = (a[15] != b[15]) && (t[15] != a[15]);
    else     e.ov = (a[15] == b[15]) && (t[15] != a[15]);
    return e;
  endfunction

  // Drive one request during a cycle, then scramble operands; returns at the negedge of cycle T+1.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub);
    @(negedge clk);
    x = a; y = b; add_n = sub; start = 1'b1;
    sbq.push_back(model(a, b, sub));
    @(negedge clk);
    start = 1'b0;
    x = 16'($urandom); y = 16'($urandom); add_n = 1'($urandom);
  endtask

  // Sample from the current negedge until done (bounded); k=1 is the current cycle.
  task automatic collect(output int nbusy, output int dcyc,
                         output logic [15:0] so, output logic co, output logic ovo);
    nbusy = 0; dcyc = -1; so = 'x; co = 'x; ovo = 'x;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        dcyc = k; so = s; co = c_out; ovo = over_flow;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; add_n = 1'b0; x = 16'hFFFF; y = 16'hFFFF;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, s, c_out, over_flow} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b s=%h c=%b ov=%b, want all 0",
               busy, done, s, c_out, over_flow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_ops(input string name, input logic [15:0] xs[], input logic [15:0] ys[],
                          input logic subs[]);
    int nb, dc; logic [15:0] so; logic co, ovo; exp_t e;
    for (int i = 0; i < xs.size(); i++) begin
      issue(xs[i], ys[i], subs[i]);
      collect(nb, dc, so, co, ovo);
      total++;
      if (nb != 4 || dc != 5) begin
        bad++;
        $display("FAIL %s_latency[%0d]: got busy_cycles=%0d done_at=%0d, want 4 5", name, i, nb, dc);
      end
      e = sbq.pop_front();
      total++;
      if (so !== e.s || co !== e.c || ovo !== e.ov) begin
        bad++;
        $display("FAIL %s_result[%0d]: got s=%h c=%b ov=%b, want s=%h c=%b ov=%b",
                 name, i, so, co, ovo, e.s, e.c, e.ov);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s_after_done[%0d]: got done=%b busy=%b, want 0 0", name, i, done, busy);
      end
    end
  endtask

  task automatic test_add();
    test_ops("add", '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000},
                    '{16'h0FFF, 16'h0001, 16'h0001, 16'h8000}, '{1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_sub();
    test_ops("sub", '{16'h8000, 16'h0005, 16'h1234, 16'h7FFF},
                    '{16'h0001, 16'h0007, 16'h1234, 16'hFFFF}, '{1'b1, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_random();
    logic [15:0] xs[], ys[]; logic subs[];
    xs = new[6]; ys = new[6]; subs = new[6];
    for (int i = 0; i < 6; i++) begin
      xs[i] = 16'($urandom); ys[i] = 16'($urandom); subs[i] = 1'($urandom);
    end
    test_ops("rand", xs, ys, subs);
  endtask

  task automatic test_ignore_start();
    int nb, dc, extra; logic [15:0] so; logic co, ovo; exp_t e;
    issue(16'h1234, 16'h0FFF, 1'b0);
    @(negedge clk);
    start = 1'b1; x = 16'hAAAA; y = 16'h5555; add_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(nb, dc, so, co, ovo);
    total++;
    if (nb != 2 || dc != 3) begin
      bad++;
      $display("FAIL ignore_latency: got busy_cycles=%0d done_at=%0d, want 2 3", nb, dc);
    end
    e = sbq.pop_front();
    total++;
    if (so !== e.s || co !== e.c || ovo !== e.ov) begin
      bad++;
      $display("FAIL ignore_result: got s=%h c=%b ov=%b, want s=%h c=%b ov=%b",
               so, co, ovo, e.s, e.c, e.ov);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_no_queue: got %0d active cycles after done, want 0", extra);
    end
  endtask

  task automatic test_reset_midop();
    int nb, dc, seen; logic [15:0] so; logic co, ovo; exp_t e;
    issue(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, s, c_out, over_flow} !== 20'h0) begin
      bad++;
      $display("FAIL midop_reset: got busy=%b done=%b s=%h c=%b ov=%b, want all 0",
               busy, done, s, c_out, over_flow);
    end
    void'(sbq.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midop_no_done: got %0d active cycles after abort, want 0", seen);
    end
    issue(16'h7FFF, 16'h0001, 1'b0);
    collect(nb, dc, so, co, ovo);
    e = sbq.pop_front();
    total++;
    if (dc != 5 || so !== e.s || co !== e.c || ovo !== e.ov) begin
      bad++;
      $display("FAIL midop_recover: got done_at=%0d s=%h c=%b ov=%b, want 5 s=%h c=%b ov=%b",
               dc, so, co, ovo, e.s, e.c, e.ov);
    end
  endtask

  task automatic test_back_to_back();
    int nb, dc; logic [15:0] so; logic co, ovo; exp_t e;
    issue(16'h0F0F, 16'h00F1, 1'b0);
    collect(nb, dc, so, co, ovo);
    e = sbq.pop_front();
    total++;
    if (dc != 5 || so !== e.s || co !== e.c || ovo !== e.ov) begin
      bad++;
      $display("FAIL b2b_first: got done_at=%0d s=%h c=%b ov=%b, want 5 s=%h c=%b ov=%b",
               dc, so, co, ovo, e.s, e.c, e.ov);
    end
    // Held from the done cycle: ignored there, accepted in the following IDLE cycle.
    start = 1'b1; x = 16'h8001; y = 16'h0003; add_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_cycle_ignored: got busy=%b, want 0", busy);
    end
    sbq.push_back(model(16'h8001, 16'h0003, 1'b1));
    @(negedge clk);
    start = 1'b0;
    collect(nb, dc, so, co, ovo);
    e = sbq.pop_front();
    total++;
    if (nb != 4 || dc != 5 || so !== e.s || co !== e.c || ovo !== e.ov) begin
      bad++;
      $display("FAIL b2b_second: got busy=%0d done_at=%0d s=%h c=%b ov=%b, want 4 5 s=%h c=%b ov=%b",
               nb, dc, so, co, ovo, e.s, e.c, e.ov);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_random();
    test_ignore_start();
    test_reset_midop();
    test_back_to_back();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got %0d leftover entries, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiword_addsub_seq.md
Name: multiword_addsub_seq

Overview:
Sequential multi-precision adder/subtractor controller.
- Reuses a single n-bit ripple-carry adder (rca_nbit) over WORDS cycles to add or subtract two n*WORDS-bit operands.
- Chains the carry between chunks through a register.
- Reports the full-width sum/difference, carry-out and signed overflow.
- Sits between a requesting datapath/controller and the shared narrow adder, trading latency for area.

Parameters:
n, 4, chunk width in bits (width of the rca_nbit instance).
WORDS, 4, number of chunks; total operand width N = n*WORDS; WORDS >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous reset, active-low.
start  input  1  request; sampled only in IDLE.
add_n  input  1  0 = add (x+y), 1 = subtract (x-y); sampled with start.
x  input  N  operand A; sampled with start.
y  input  N  operand B; sampled with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result is complete.
s  output  N  result register.
c_out  output  1  carry out of bit N-1. For subtract, 1 = no borrow.
over_flow  output  1  two's-complement signed overflow of the full-width operation.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; x/y/add_n latches, carry register, chunk index, s, c_out, over_flow, busy and done all 0.
- States, encoded IDLE=2'b00, RUN=2'b01, DONE=2'b10:
  - IDLE: on start=1, latch x, y and add_n. Set carry <= add_n, idx <= 0. Go to RUN.
  - RUN: chunk idx uses a = x[idx*n +: n], b = y[idx*n +: n] ^ {n{add_n}}, c_in = carry.
    - Write the rca sum to s[idx*n +: n]; carry <= rca c_out; idx <= idx+1.
    - When idx==WORDS-1, instead of incrementing:
      - c_out <= rca c_out.
      - over_flow <= (x[N-1] & ye & ~sm) | (~x[N-1] & ~ye & sm), where ye = y[N-1]^add_n and sm = the MSB of the chunk sum being written.
      - Go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: if start is sampled high at the end of cycle T, busy is high in cycles T+1..T+WORDS and done is high in cycle T+WORDS+1.
  - s, c_out and over_flow are valid from the done cycle and hold until the next accepted start.
- Intermediate s: s is overwritten chunk by chunk during RUN. Upper chunks keep the previous result until written. Consumers use s only at or after done.
- start while busy or in DONE: ignored, no queuing. Operand inputs may change freely after acceptance.
- Back-to-back: start asserted in the done cycle is ignored. It is accepted in the following IDLE cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse for the aborted request.
- idx width: clog2(WORDS). No wrap-around beyond WORDS-1.
- Arithmetic is modulo 2^N. No saturation.

Decomposition:
- Shared package/header: state encodings (IDLE, RUN, DONE) and a clog2 function/constant for the idx width.
- One sub-module: rca_nbit #(.n(n)), instantiated once as the chunk adder.
- Operand inversion, overflow logic and the FSM stay in this block.

Test Plan:
All scenarios use n=4, WORDS=4 (N=16).
1. add_n=0, x=16'h1234, y=16'h0FFF, start at T -> busy in T+1..T+4; done in T+5; s=16'h2233, c_out=0, over_flow=0.
2. add_n=0, x=16'hFFFF, y=16'h0001 (carry ripples through all chunks) -> s=16'h0000, c_out=1, over_flow=0.
3. add_n=0, x=16'h7FFF, y=16'h0001 -> s=16'h8000, c_out=0, over_flow=1. Then add_n=1, x=16'h8000, y=16'h0001 -> s=16'h7FFF, c_out=1, over_flow=1.
4. add_n=1, x=16'h0005, y=16'h0007 -> s=16'hFFFE, c_out=0 (borrow), over_flow=0.
5. Change start/x/y during RUN: start=1 with x=16'hAAAA in cycle T+2 -> ignored; the result equals the originally latched request. A single done pulse is seen.
6. Reset mid-op: rst_n low during cycle T+2 -> s=0, c_out=0, over_flow=0, busy=0 immediately, no done pulse. A new start after release completes normally with the correct result.
